// File: rtl/univ_shift_reg.sv
// Universal shift register with hold/load/shift/rotate/clear ops
// and an FSM-driven autonomous serial burst of up to 2**CW-1 shifts.
`timescale 1ns/1ps
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int CW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CW-1:0]    cnt,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    rem_q, rem_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = (cnt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          // rem_q==0 here is unreachable; treat it as the last shift
          if (rem_q <= CW'(1)) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE) && en;
    sout = dir_q ? q_q[0] : q_q[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= RST_VAL;
      dir_q <= 1'b0;
      rem_q <= '0;
    end else begin
      q_q   <= q_d;
      dir_q <= dir_d;
      rem_q <= rem_d;
    end
  end

  always_comb begin
    q_d   = q_q;
    dir_d = dir_q;
    rem_d = rem_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dir_d = dir;
            rem_d = cnt;
          end else begin
            unique case (mode)
              3'b001: q_d = d;
              3'b010: begin
                q_d   = {q_q[WIDTH-2:0], sin};
                dir_d = 1'b0;
              end
              3'b011: begin
                q_d   = {sin, q_q[WIDTH-1:1]};
                dir_d = 1'b1;
              end
              3'b100: begin
                q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                dir_d = 1'b0;
              end
              3'b101: begin
                q_d   = {q_q[0], q_q[WIDTH-1:1]};
                dir_d = 1'b1;
              end
              3'b110:  q_d = '0;
              default: q_d = q_q;
            endcase
          end
        end
        SHIFT: begin
          q_d = dir_q ? {sin, q_q[WIDTH-1:1]}
                      : {q_q[WIDTH-2:0], sin};
          if (rem_q != '0) begin
            rem_d = rem_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed-vector bench for univ_shift_reg (WIDTH=8, CW=4).
// Inputs change 1ns after each rising edge; outputs sampled there.
`timescale 1ns/1ps
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst, en, sin, start, dir;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] cnt;
  logic [7:0] q;
  logic       sout, busy, done;

  int vec = 0;
  int miss = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00), .CW(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin(sin), .start(start), .cnt(cnt), .dir(dir),
    .q(q), .sout(sout), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] qe,
                     input logic be, input logic de);
    vec++;
    if (q !== qe || busy !== be || done !== de) begin
      miss++;
      $display("FAIL %s: q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
               nm, q, busy, done, qe, be, de);
    end
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] dd,
                    input logic s);
    mode = m; d = dd; sin = s; start = 1'b0;
    tick();
    mode = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 3'b000; d = 8'h00;
    sin = 1'b0; start = 1'b0; cnt = 4'd0; dir = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_init", 8'h00, 1'b0, 1'b0);
    op(3'b001, 8'hA5, 1'b0);
    start = 1'b1; cnt = 4'd5; dir = 1'b0;
    tick();
    start = 1'b0;
    chk("reset_pre_busy", 8'hA5, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_mid_burst", 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("reset_no_done", 8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic test_rotate();
    op(3'b001, 8'h81, 1'b0);
    chk("load_81", 8'h81, 1'b0, 1'b0);
    op(3'b100, 8'h00, 1'b0);
    chk("rotl", 8'h03, 1'b0, 1'b0);
    op(3'b101, 8'h00, 1'b0);
    op(3'b101, 8'h00, 1'b0);
    chk("rotr_x2", 8'hC0, 1'b0, 1'b0);
    op(3'b111, 8'hFF, 1'b1);
    chk("reserved_hold", 8'hC0, 1'b0, 1'b0);
    op(3'b110, 8'hFF, 1'b1);
    chk("clr", 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_shift();
    op(3'b001, 8'hB4, 1'b0);
    op(3'b011, 8'h00, 1'b1);
    chk("shr", 8'hDA, 1'b0, 1'b0);
    vec++;
    if (sout !== 1'b0) begin
      miss++; $display("FAIL shr_sout: got %b want 0", sout);
    end
    op(3'b010, 8'h00, 1'b0);
    chk("shl", 8'hB4, 1'b0, 1'b0);
    vec++;
    if (sout !== 1'b1) begin
      miss++; $display("FAIL shl_sout: got %b want 1", sout);
    end
    en = 1'b0;
    op(3'b001, 8'h55, 1'b0);
    en = 1'b1;
    chk("en0_hold", 8'hB4, 1'b0, 1'b0);
  endtask

  task automatic test_burst();
    logic [7:0] exp_q [3] = '{8'hE1, 8'hC3, 8'h87};
    op(3'b001, 8'hF0, 1'b0);
    start = 1'b1; cnt = 4'd3; dir = 1'b0; sin = 1'b1;
    tick();
    start = 1'b0;
    chk("burst_start", 8'hF0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("burst_shift%0d", i), exp_q[i],
          (i < 2), (i == 2));
    end
    vec++;
    if (sout !== 1'b1) begin
      miss++; $display("FAIL burst_sout: got %b want 1", sout);
    end
    tick();
    chk("burst_idle", 8'h87, 1'b0, 1'b0);
  endtask

  task automatic test_zero_burst();
    start = 1'b1; cnt = 4'd0; dir = 1'b1; sin = 1'b0;
    tick();
    start = 1'b0;
    chk("zero_done", 8'h87, 1'b0, 1'b1);
    tick();
    chk("zero_idle", 8'h87, 1'b0, 1'b0);
    vec++;
    if (sout !== 1'b1) begin
      miss++; $display("FAIL zero_dir_sout: got %b want 1", sout);
    end
  endtask

  task automatic test_freeze();
    op(3'b001, 8'h0F, 1'b0);
    start = 1'b1; cnt = 4'd4; dir = 1'b1; sin = 1'b1;
    tick();
    chk("frz_start", 8'h0F, 1'b1, 1'b0);
    mode = 3'b001; d = 8'hFF; start = 1'b1;
    tick();
    chk("frz_ignore_start", 8'h87, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b110;
    tick();
    chk("frz_ignore_mode", 8'hC3, 1'b1, 1'b0);
    mode = 3'b000; en = 1'b0;
    tick();
    chk("frz_hold1", 8'hC3, 1'b1, 1'b0);
    tick();
    chk("frz_hold2", 8'hC3, 1'b1, 1'b0);
    en = 1'b1;
    tick();
    chk("frz_shift3", 8'hE1, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    chk("frz_hold3", 8'hE1, 1'b1, 1'b0);
    en = 1'b1;
    tick();
    chk("frz_shift4", 8'hF0, 1'b0, 1'b1);
    en = 1'b0;
    #1;
    chk("frz_done_gated", 8'hF0, 1'b0, 1'b0);
    tick();
    chk("frz_done_held", 8'hF0, 1'b0, 1'b0);
    en = 1'b1; start = 1'b1; cnt = 4'd2;
    #1;
    chk("frz_done_pulse", 8'hF0, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    chk("frz_done_start_ign", 8'hF0, 1'b0, 1'b0);
    tick();
    chk("frz_final", 8'hF0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_shift();
    test_burst();
    test_zero_burst();
    test_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
